// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: valid/ready request with opcode and
// operands, valid/ready response with result, branch flag and error flag.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_func;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_check;
  logic            alu_err;

  // Producer side: issues requests, consumes results.
  modport master (
    output in_valid, alu_func, in_a, in_b, out_ready,
    input  in_ready, out_valid, alu_result, alu_check, alu_err
  );

  // Execution unit side.
  modport slave (
    input  in_valid, alu_func, in_a, in_b, out_ready,
    output in_ready, out_valid, alu_result, alu_check, alu_err
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle execute unit. Single-cycle arithmetic/logic/compare ops,
// bit-serial shifts (one position per cycle), registered outputs held in
// DONE until the consumer takes them.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus
);
  // Opcode encoding shared with ALU control.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_BGE  = 4'hA;
  localparam logic [3:0] OP_BGEU = 4'hB;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      func_q, func_d;    // shift kind while iterating
  logic [XLEN-1:0] work_q, work_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            chk_q, chk_d;
  logic            err_q, err_d;

  logic            accept;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] shifted;
  logic            lt_s, lt_u;

  // out_ready -> in_ready is the only combinational path through the unit.
  assign bus.in_ready   = !rst && ((state_q == IDLE) ||
                                   (state_q == DONE && bus.out_ready));
  assign bus.out_valid  = (state_q == DONE);
  assign bus.alu_result = res_q;
  assign bus.alu_check  = chk_q;
  assign bus.alu_err    = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign diff   = bus.in_a - bus.in_b;
  assign lt_s   = $signed(bus.in_a) < $signed(bus.in_b);
  assign lt_u   = bus.in_a < bus.in_b;

  // One-position shift of the work register for the latched shift kind.
  always_comb begin
    shifted = work_q;
    case (func_q)
      OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: shifted = work_q;
    endcase
  end

  // Next-state and datapath: decode on accept, iterate shifts, hold in DONE.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    chk_d   = chk_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
        if (accept) begin
          state_d = DONE;
          chk_d   = 1'b0;
          err_d   = 1'b0;
          res_d   = '0;
          case (bus.alu_func)
            OP_ADD:  res_d = bus.in_a + bus.in_b;
            OP_SUB:  begin res_d = diff; chk_d = (bus.in_a == bus.in_b); end
            OP_XOR:  res_d = bus.in_a ^ bus.in_b;
            OP_OR:   res_d = bus.in_a | bus.in_b;
            OP_AND:  res_d = bus.in_a & bus.in_b;
            OP_SLT:  res_d = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: res_d = {{(XLEN-1){1'b0}}, lt_u};
            OP_BGE:  begin res_d = diff; chk_d = !lt_s; end
            OP_BGEU: begin res_d = diff; chk_d = !lt_u; end
            OP_SLL, OP_SRL, OP_SRA: begin
              func_d = bus.alu_func;
              work_d = bus.in_a;
              cnt_d  = bus.in_b[4:0];
              // Zero shift amount skips the iteration entirely.
              if (bus.in_b[4:0] == 5'd0) res_d   = bus.in_a;
              else                       state_d = SHIFT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          res_d   = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      func_q  <= 4'h0;
      work_q  <= '0;
      cnt_q   <= 5'd0;
      res_q   <= '0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed vectors for every op class,
// shift latency, backpressure, back-to-back throughput and reset abort.
module tb_seq_alu;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_BGE  = 4'hA;
  localparam logic [3:0] OP_BGEU = 4'hB;
  localparam logic [3:0] OP_EEE  = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_alu_if #(.XLEN(32)) ifc ();

  seq_alu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, measure latency to out_valid, check
  // outputs, then retire it.
  task automatic run_op(input string tag, input logic [3:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic e_chk,
                        input logic e_err, input int e_lat);
    int lat;
    chk({tag, ".rdy"}, 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.alu_func = f;
    ifc.in_a     = a;
    ifc.in_b     = b;
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_a     = 32'hDEAD_BEEF;
    ifc.in_b     = 32'h0BAD_F00D;
    lat = 1;
    while (!ifc.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    chk({tag, ".res"}, ifc.alu_result, e_res);
    chk({tag, ".chk"}, 32'(ifc.alu_check), 32'(e_chk));
    chk({tag, ".err"}, 32'(ifc.alu_err), 32'(e_err));
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk({tag, ".idle"}, 32'(ifc.out_valid), 32'd0);
  endtask

  logic [31:0] b2b_a [4] = '{32'd1, 32'd100, 32'hFFFF_FFFF, 32'h1234_0000};
  logic [31:0] b2b_b [4] = '{32'd2, 32'd200, 32'd2,         32'h0000_5678};
  logic [31:0] b2b_e [4] = '{32'd3, 32'd300, 32'd1,         32'h1234_5678};

  initial begin
    int seen;
    ifc.in_valid  = 1'b0;
    ifc.alu_func  = OP_ADD;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.out_ready = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst.ovld", 32'(ifc.out_valid), 32'd0);
    chk("rst.res",  ifc.alu_result, 32'd0);
    chk("rst.chk",  32'(ifc.alu_check), 32'd0);
    chk("rst.err",  32'(ifc.alu_err), 32'd0);
    chk("rst.rdy",  32'(ifc.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post.rdy", 32'(ifc.in_ready), 32'd1);

    // Single-cycle ops.
    run_op("add",  OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1);
    run_op("sub",  OP_SUB,  32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    run_op("subn", OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run_op("bge",  OP_BGE,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run_op("bgeu", OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
    run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run_op("xor",  OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b0, 1);
    run_op("or",   OP_OR,   32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1'b0, 1'b0, 1);
    run_op("and",  OP_AND,  32'hF0F0_FFFF, 32'h3C3C_00F0, 32'h3030_00F0, 1'b0, 1'b0, 1);

    // Shifts: latency shamt+1, upper bits of in_b ignored.
    run_op("sra4",  OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 1'b0, 1'b0, 5);
    run_op("sll0",  OP_SLL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1);
    run_op("srl31", OP_SRL, 32'hFFFF_FFFF, 32'd31, 32'd1, 1'b0, 1'b0, 32);
    run_op("sll3",  OP_SLL, 32'h8000_0011, 32'd3, 32'h0000_0088, 1'b0, 1'b0, 4);

    // Backpressure: result frozen, new requests refused.
    ifc.in_valid = 1'b1;
    ifc.alu_func = OP_ADD;
    ifc.in_a     = 32'd3;
    ifc.in_b     = 32'd4;
    tick();
    ifc.alu_func = OP_SUB;
    for (int i = 0; i < 10; i++) begin
      ifc.in_a = 32'(100 + i);
      ifc.in_b = 32'(i);
      chk("bp.ovld", 32'(ifc.out_valid), 32'd1);
      chk("bp.res",  ifc.alu_result, 32'd7);
      chk("bp.rdy",  32'(ifc.in_ready), 32'd0);
      tick();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    chk("bp.rdy1", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("bp.once", 32'(ifc.out_valid), 32'd0);
    ifc.out_ready = 1'b0;

    // Back-to-back ADDs: one result per cycle in order.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_func  = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      ifc.in_a = b2b_a[i];
      ifc.in_b = b2b_b[i];
      tick();
      chk("b2b.ovld", 32'(ifc.out_valid), 32'd1);
      chk("b2b.res",  ifc.alu_result, b2b_e[i]);
    end
    ifc.in_valid = 1'b0;
    tick();
    chk("b2b.end", 32'(ifc.out_valid), 32'd0);
    ifc.out_ready = 1'b0;

    // Reset mid-shift aborts the op with no response.
    ifc.in_valid = 1'b1;
    ifc.alu_func = OP_SLL;
    ifc.in_a     = 32'd1;
    ifc.in_b     = 32'd20;
    tick();
    ifc.in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("abort.ovld", 32'(ifc.out_valid), 32'd0);
    chk("abort.res",  ifc.alu_result, 32'd0);
    chk("abort.rdy",  32'(ifc.in_ready), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (ifc.out_valid) seen++;
      tick();
    end
    chk("abort.none", 32'(seen), 32'd0);

    // Undefined codes flag an error with zero result.
    run_op("und",  4'hE,   32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1);
    run_op("add2", OP_ADD, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0, 1);
    run_op("eee",  OP_EEE, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
